sqrt_ctrl: RTL
==============

# sqrt_ctrl

Sequencer for the FP16 square-root unit. Accepts one operand at a time over a valid/ready handshake and issues it to the special-case classification stage. Special results (NaN, ±Inf, ±0, negative operands) return directly. Normal and subnormal operands are launched on the iterative sqrt core, and the controller waits for its completion. The block sits between the unit's external port and the `special` stage / iterative core pair.

## Interface
Parameters:
- `CORE_TIMEOUT`, default 64: maximum RUN cycles before abort. Used only with `SQRT_CTRL_TIMEOUT_EN`. Counter width is `$clog2(CORE_TIMEOUT+1)`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand offered.
- `in_ready`  out  1  controller can accept an operand.
- `in_data`  in  16  FP16 operand {sign, exp[4:0], mant[9:0]}.
- `sp_enable`  out  1  enable to the special stage.
- `sp_valid`  out  1  valid to the special stage.
- `sp_data`  out  16  operand driven to the special stage.
- `sp_s_valid`  in  1  special stage result valid.
- `sp_is_nan`, `sp_is_pinf`, `sp_is_ninf`, `sp_is_normal`, `sp_is_subnormal`  in  1 each  special stage class flags.
- `sp_result`  in  16  special stage {sign_out, exp_out, mant_out}.
- `core_start`  out  1  one-cycle launch pulse to the iterative core.
- `core_operand`  out  16  operand for the core, held stable through RUN.
- `core_done`  in  1  core completion pulse.
- `core_result`  in  16  core result, valid with `core_done`.
- `core_abort`  out  1  one-cycle abort pulse. Exists only with `SQRT_CTRL_TIMEOUT_EN`; otherwise tied 0.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  16  FP16 result.
- `out_err`  out  1  result produced by timeout. Tied 0 without the macro.
- `busy`  out  1  state is not IDLE.

## Operation
FSM states: IDLE, ISSUE, WAIT_SP, RUN, DONE.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid & in_ready`: latch `in_data` into `sp_data`, go to ISSUE.
- **ISSUE**
  - `sp_enable=1`, `sp_valid=1` for exactly one cycle. Go to WAIT_SP.
- **WAIT_SP**
  - `sp_enable=1`, `sp_valid=0`.
  - On `sp_s_valid`:
    - `sp_is_normal | sp_is_subnormal`: latch `sp_result` into `core_operand`, pulse `core_start` next cycle, go to RUN.
    - `sp_is_ninf`: `out_data=16'hFE00`, go to DONE.
    - Otherwise (NaN, +Inf, ±0): `out_data=sp_result`, go to DONE. This passes through NaN payload/sign and zero sign as computed by the stage.
- **RUN**
  - Wait for `core_done`. On `core_done`: `out_data=core_result`, go to DONE.
- **DONE**
  - `out_valid=1`. `out_data`/`out_err` stable until `out_ready`.
  - On `out_ready`: go to IDLE.
- Outside ISSUE and WAIT_SP: `sp_enable=0`, `sp_valid=0`.
- `core_done` in any state other than RUN is ignored.
- Inputs arriving while not IDLE are not accepted (`in_ready=0`).

## Timing
- Reset (async, `rst_n` low):
  - state IDLE.
  - Outputs 0: `in_ready`, `sp_*`, `core_start`, `core_abort`, `out_valid`, `out_err`, `busy`.
  - Data registers 0: `sp_data`, `core_operand`, `out_data`.
  - `in_ready` rises at the first rising edge after `rst_n` deasserts.
- Bypass latency: handshake at cycle N gives ISSUE at N+1, `sp_s_valid` at N+2, `out_valid` at N+3.
- Core path: `core_start` at N+3; `out_valid` one cycle after `core_done`.
- Throughput: at most one operand in flight. The next `in_ready` comes one cycle after the `out_valid & out_ready` handshake.
- Reset asserted in any state aborts the operation immediately. No `out_valid` is produced for the aborted operand.
- All outputs are registered except `in_ready`, `busy` and `out_valid`, which decode the state register directly.

## Configuration
`SQRT_CTRL_TIMEOUT_EN`:
- **Defined:**
  - A counter clears on RUN entry and increments each RUN cycle.
  - If `core_done` is not seen by count `CORE_TIMEOUT`: pulse `core_abort`, set `out_data=16'h7E00`, `out_err=1`, go to DONE.
  - `core_done` arriving in the same cycle as expiry wins; `out_err=0`.
  - `out_err` clears on the `out_ready` handshake.
- **Undefined:**
  - No counter. RUN waits indefinitely.
  - `core_abort=0`, `out_err=0`.

## Test plan
- `in_data=16'h4400` (4.0), core model answers `16'h4000` after 12 cycles: `core_start` at N+3 with `core_operand=16'h4400`; `out_data=16'h4000` one cycle after `core_done`.
- `16'h7C00` (+Inf): `out_valid` at N+3, `out_data=16'h7C00`, `core_start` never asserted. `16'hFC00` (-Inf): `out_data=16'hFE00`.
- `16'hC000` (-2.0): `out_data=16'hFE00`. `16'h8000` (-0): `out_data=16'h8000`. `16'h7D00` (sNaN): `out_data=16'h7F00`.
- `out_ready` low for 5 cycles in DONE: `out_valid`/`out_data` held, `in_ready=0`; `in_ready` rises the cycle after the handshake.
- With macro, `CORE_TIMEOUT=8`, core silent: `core_abort` pulse, `out_data=16'h7E00`, `out_err=1`. Late `core_done` in IDLE is ignored.
- `rst_n` pulsed low mid-RUN: all outputs at reset values immediately, `in_ready=1` the next edge after release, no spurious `out_valid`.

Source files
------------

// File: rtl/sqrt_ctrl.sv
// sqrt_ctrl: sequences one FP16 operand through the special-case stage and, for
// finite positive operands, the iterative sqrt core. Bypass result 3 cycles after
// accept; core path result 1 cycle after core_done. One operand in flight; the
// result is held in DONE until out_ready. Optional timeout: SQRT_CTRL_TIMEOUT_EN.
module sqrt_ctrl #(
   parameter int CORE_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        sp_enable,
   output logic        sp_valid,
   output logic [15:0] sp_data,
   input  logic        sp_s_valid,
   input  logic        sp_is_nan,
   input  logic        sp_is_pinf,
   input  logic        sp_is_ninf,
   input  logic        sp_is_normal,
   input  logic        sp_is_subnormal,
   input  logic [15:0] sp_result,
   output logic        core_start,
   output logic [15:0] core_operand,
   input  logic        core_done,
   input  logic [15:0] core_result,
   output logic        core_abort,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT_SP = 3'd2,
      S_RUN     = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   // Canonical quiet NaN with the sign bit set: result for sqrt of a negative value.
   localparam logic [15:0] NEG_QNAN = 16'hFE00;

   state_t      state_q, state_d;
   logic        live_q;
   logic        sp_enable_q, sp_enable_d;
   logic        sp_valid_q, sp_valid_d;
   logic [15:0] sp_data_q, sp_data_d;
   logic        core_start_q, core_start_d;
   logic [15:0] core_operand_q, core_operand_d;
   logic [15:0] out_data_q, out_data_d;

   // NaN and +Inf need no dedicated handling: their stage result is passed through.
   logic unused_ok;
   assign unused_ok = sp_is_nan ^ sp_is_pinf ^ (CORE_TIMEOUT > 0);

`ifdef SQRT_CTRL_TIMEOUT_EN
   localparam int CW = $clog2(CORE_TIMEOUT + 1);
   logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          core_abort_q, core_abort_d;
   logic          out_err_q, out_err_d;
`endif

   // in_ready stays low until the first clock edge after reset release.
   assign in_ready  = (state_q == S_IDLE) && live_q;
   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_DONE);

   assign sp_enable    = sp_enable_q;
   assign sp_valid     = sp_valid_q;
   assign sp_data      = sp_data_q;
   assign core_start   = core_start_q;
   assign core_operand = core_operand_q;
   assign out_data     = out_data_q;
`ifdef SQRT_CTRL_TIMEOUT_EN
   assign core_abort   = core_abort_q;
   assign out_err      = out_err_q;
`else
   assign core_abort   = 1'b0;
   assign out_err      = 1'b0;
`endif

   // Next-state and registered-output decode; pulses default low, data regs hold.
   always_comb begin
      state_d        = state_q;
      sp_enable_d    = 1'b0;
      sp_valid_d     = 1'b0;
      sp_data_d      = sp_data_q;
      core_start_d   = 1'b0;
      core_operand_d = core_operand_q;
      out_data_d     = out_data_q;
`ifdef SQRT_CTRL_TIMEOUT_EN
      tmo_cnt_d      = tmo_cnt_q;
      core_abort_d   = 1'b0;
      out_err_d      = out_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               sp_data_d   = in_data;
               sp_valid_d  = 1'b1;
               sp_enable_d = 1'b1;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            sp_enable_d = 1'b1;
            state_d     = S_WAIT_SP;
         end
         S_WAIT_SP: begin
            sp_enable_d = 1'b1;
            if (sp_s_valid) begin
               sp_enable_d = 1'b0;
               if (sp_is_normal || sp_is_subnormal) begin
                  core_operand_d = sp_result;
                  core_start_d   = 1'b1;
                  state_d        = S_RUN;
`ifdef SQRT_CTRL_TIMEOUT_EN
                  tmo_cnt_d      = '0;
`endif
               end else if (sp_is_ninf) begin
                  out_data_d = NEG_QNAN;
                  state_d    = S_DONE;
               end else begin
                  out_data_d = sp_result;
                  state_d    = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (core_done) begin
               // A completion in the expiry cycle still counts as a real result.
               out_data_d = core_result;
               state_d    = S_DONE;
`ifdef SQRT_CTRL_TIMEOUT_EN
               out_err_d  = 1'b0;
            end else if (tmo_cnt_q == CW'(CORE_TIMEOUT - 1)) begin
               core_abort_d = 1'b1;
               out_data_d   = 16'h7E00;
               out_err_d    = 1'b1;
               state_d      = S_DONE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CW'(1);
`endif
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d   = S_IDLE;
`ifdef SQRT_CTRL_TIMEOUT_EN
               out_err_d = 1'b0;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; async reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         live_q         <= 1'b0;
         sp_enable_q    <= 1'b0;
         sp_valid_q     <= 1'b0;
         sp_data_q      <= '0;
         core_start_q   <= 1'b0;
         core_operand_q <= '0;
         out_data_q     <= '0;
`ifdef SQRT_CTRL_TIMEOUT_EN
         tmo_cnt_q      <= '0;
         core_abort_q   <= 1'b0;
         out_err_q      <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         live_q         <= 1'b1;
         sp_enable_q    <= sp_enable_d;
         sp_valid_q     <= sp_valid_d;
         sp_data_q      <= sp_data_d;
         core_start_q   <= core_start_d;
         core_operand_q <= core_operand_d;
         out_data_q     <= out_data_d;
`ifdef SQRT_CTRL_TIMEOUT_EN
         tmo_cnt_q      <= tmo_cnt_d;
         core_abort_q   <= core_abort_d;
         out_err_q      <= out_err_d;
`endif
      end
   end

endmodule
